// File: rtl/net_pkg.sv
// Shared networking definitions for the RX parser, status capture and the
// ARP reply scheduler.
//   pkt_type_e   : per-packet type strobe encoding from the RX parser
//   arp_snap_t   : fields frozen when an ARP request is accepted
//   arp_state_e  : reply scheduler state
//   ARP / Ethernet header constants used to build the reply frame
package net_pkg;

  typedef enum logic [1:0] {
    PKT_NONE    = 2'd0,
    PKT_ARP_REQ = 2'd1,
    PKT_ARP_RPL = 2'd2,
    PKT_OTHER   = 2'd3
  } pkt_type_e;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
  localparam int          ARP_REPLY_WORDS = 11;

  // Word index width; covers 0..ARP_REPLY_WORDS-1.
  localparam int IDX_W = 4;

  typedef struct packed {
    logic [47:0] sha;  // requester MAC, becomes destination and THA
    logic [31:0] spa;  // requester IP, becomes TPA
    logic [47:0] mac;  // our MAC at accept time
    logic [31:0] ip;   // our IP at accept time
  } arp_snap_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arp_state_e;

endpackage

// File: rtl/arp_reply_fmt.sv
// ARP reply word formatter: purely combinational mux from a word index and a
// field snapshot to one 32-bit big-endian frame word.
//   idx  : word index 0..10
//   snap : frozen request / local address fields
//   data : frame word for idx (0 for out-of-range index)
//   last : high for the final word (index 10)
module arp_reply_fmt
  import net_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  arp_snap_t        snap,
  output logic [31:0]      data,
  output logic             last
);

  always_comb begin
    data = '0;
    last = 1'b0;
    case (idx)
      // Ethernet header: dst = requester, src = us, type = ARP
      4'd0:  data = snap.sha[47:16];
      4'd1:  data = {snap.sha[15:0], snap.mac[47:32]};
      4'd2:  data = snap.mac[31:0];
      4'd3:  data = {ETHERTYPE_ARP, ARP_HTYPE_ETH};
      // ARP body: PTYPE, HLEN=6, PLEN=4, OPER=reply, SHA/SPA = us
      4'd4:  data = {ARP_PTYPE_IP, 8'h06, 8'h04};
      4'd5:  data = {ARP_OPER_REPLY, snap.mac[47:32]};
      4'd6:  data = snap.mac[31:0];
      4'd7:  data = snap.ip;
      // THA/TPA = requester; trailing half-word zero padded
      4'd8:  data = snap.sha[47:16];
      4'd9:  data = {snap.sha[15:0], snap.spa[31:16]};
      4'd10: begin
        data = {snap.spa[15:0], 16'h0000};
        last = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arp_reply_sched.sv
// ARP reply scheduler. Qualifies ARP requests aimed at the local IP from the
// RX capture strobe, streams an 11-word reply on a valid/ready TX interface,
// then holds off for HOLDOFF_CYCLES before accepting another request.
//   clk, rst_n      : clock, synchronous active-low reset
//   i_enable        : responder armed (checked only when a request qualifies)
//   i_pkt_type      : one-cycle per-packet type strobe
//   i_SHA/SPA/TPA   : captured ARP fields of the parsed packet
//   i_local_mac/ip  : our addresses
//   o_tx_*          : TX word stream (data, valid, last) with i_tx_ready
//   o_busy          : not idle
//   o_reply_cnt     : frames completed (saturating)
//   o_drop_cnt      : qualified requests dropped while busy (saturating)
module arp_reply_sched
  import net_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [1:0]       i_pkt_type,
  input  logic [47:0]      i_SHA,
  input  logic [31:0]      i_SPA,
  input  logic [31:0]      i_TPA,
  input  logic [47:0]      i_local_mac,
  input  logic [31:0]      i_local_ip,
  output logic [31:0]      o_tx_data,
  output logic             o_tx_valid,
  output logic             o_tx_last,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_reply_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam int GAP_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int GAP_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LOAD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arp_state_e       state;
  arp_snap_t        snap;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;

  logic             qual, fire, load;
  logic [IDX_W-1:0] fmt_idx;
  arp_snap_t        fmt_snap;
  logic [31:0]      fmt_data;
  logic             fmt_last;

  assign qual = (i_pkt_type == PKT_ARP_REQ) && (i_TPA == i_local_ip) && i_enable;
  assign fire = o_tx_valid && i_tx_ready;
  assign load = (state == ST_IDLE) && qual;

  // The formatter is fed with the values that will be registered this cycle,
  // so the output word is registered and W0 appears one cycle after accept
  // already built from the freshly captured fields.
  always_comb begin
    fmt_idx  = load ? '0 : idx + IDX_W'(1);
    fmt_snap = snap;
    if (load) begin
      fmt_snap.sha = i_SHA;
      fmt_snap.spa = i_SPA;
      fmt_snap.mac = i_local_mac;
      fmt_snap.ip  = i_local_ip;
    end
  end

  arp_reply_fmt u_fmt (
    .idx  (fmt_idx),
    .snap (fmt_snap),
    .data (fmt_data),
    .last (fmt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snap        <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_tx_last   <= 1'b0;
      o_reply_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      // Any qualified request outside IDLE is lost, including one arriving
      // in the same cycle the last word is accepted.
      if (qual && (state != ST_IDLE) && (o_drop_cnt != CNT_MAX))
        o_drop_cnt <= o_drop_cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (qual) begin
            snap       <= fmt_snap;
            idx        <= '0;
            o_tx_data  <= fmt_data;
            o_tx_last  <= fmt_last;
            o_tx_valid <= 1'b1;
            state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          // Data/last only move on an accepted beat, so they stay stable
          // while the sink stalls.
          if (fire) begin
            if (o_tx_last) begin
              o_tx_valid <= 1'b0;
              o_tx_last  <= 1'b0;
              o_tx_data  <= '0;
              idx        <= '0;
              if (o_reply_cnt != CNT_MAX)
                o_reply_cnt <= o_reply_cnt + CNT_W'(1);
              if (HOLDOFF_CYCLES == 0) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_INIT;
              end
            end else begin
              idx       <= fmt_idx;
              o_tx_data <= fmt_data;
              o_tx_last <= fmt_last;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) state   <= ST_IDLE;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_arp_reply_sched.sv
// Testbench for arp_reply_sched: directed scenarios followed by random
// traffic, checked every cycle against a frame-queue reference model.
// A second instance with 2-bit counters shares all inputs to exercise
// counter saturation.
module tb_arp_reply_sched;
  import net_pkg::*;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [1:0]  i_pkt_type;
  logic [47:0] i_SHA;
  logic [31:0] i_SPA, i_TPA;
  logic [47:0] i_local_mac;
  logic [31:0] i_local_ip;
  logic        i_tx_ready;

  logic [31:0] o_tx_data, o2_tx_data;
  logic        o_tx_valid, o_tx_last, o_busy;
  logic        o2_tx_valid, o2_tx_last, o2_busy;
  logic [15:0] o_reply_cnt, o_drop_cnt;
  logic [1:0]  o2_reply_cnt, o2_drop_cnt;

  always #5 clk = ~clk;

  arp_reply_sched #(.HOLDOFF_CYCLES(HOLD), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pkt_type(i_pkt_type),
    .i_SHA(i_SHA), .i_SPA(i_SPA), .i_TPA(i_TPA),
    .i_local_mac(i_local_mac), .i_local_ip(i_local_ip),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_reply_cnt(o_reply_cnt), .o_drop_cnt(o_drop_cnt)
  );

  arp_reply_sched #(.HOLDOFF_CYCLES(HOLD), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pkt_type(i_pkt_type),
    .i_SHA(i_SHA), .i_SPA(i_SPA), .i_TPA(i_TPA),
    .i_local_mac(i_local_mac), .i_local_ip(i_local_ip),
    .o_tx_data(o2_tx_data), .o_tx_valid(o2_tx_valid), .o_tx_last(o2_tx_last),
    .i_tx_ready(i_tx_ready), .o_busy(o2_busy),
    .o_reply_cnt(o2_reply_cnt), .o_drop_cnt(o2_drop_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: words still to be sent, remaining hold-off cycles,
  // unbounded event counts (saturation applied when comparing).
  logic [31:0] mq[$];
  int          gap_left = 0;
  int          m_reply = 0;
  int          m_drop = 0;
  logic [31:0] acc[$];

  logic [31:0] exp1 [11];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reply frame as the wire should carry it, written out field by field.
  task automatic push_frame(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [47:0] mac, input logic [31:0] ip);
    logic [111:0] eth;
    logic [223:0] arp;
    logic [351:0] frm;
    eth = {sha, mac, 16'h0806};
    arp = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, mac, ip, sha, spa};
    frm = {eth, arp, 16'h0000};
    for (int w = 0; w < 11; w++) mq.push_back(frm[351 - 32*w -: 32]);
  endtask

  task automatic model_update();
    logic q;
    q = (i_pkt_type == 2'd1) && (i_TPA == i_local_ip) && i_enable;
    if (!rst_n) begin
      mq.delete();
      gap_left = 0;
      m_reply  = 0;
      m_drop   = 0;
    end else if (mq.size() > 0) begin
      if (q) m_drop++;
      if (i_tx_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_reply++;
          gap_left = HOLD;
        end
      end
    end else if (gap_left > 0) begin
      if (q) m_drop++;
      gap_left--;
    end else if (q) begin
      push_frame(i_SHA, i_SPA, i_local_mac, i_local_ip);
    end
  endtask

  task automatic check_all();
    logic        ev;
    logic [31:0] ed;
    ev = (mq.size() > 0);
    ed = ev ? mq[0] : 32'h0;
    chk("valid", o_tx_valid, ev);
    chk("data",  o_tx_data, ed);
    chk("last",  o_tx_last, mq.size() == 1);
    chk("busy",  o_busy, ev || (gap_left > 0));
    chk("reply_cnt", o_reply_cnt, sat(m_reply, 65535));
    chk("drop_cnt",  o_drop_cnt,  sat(m_drop, 65535));
    chk("sat_valid", o2_tx_valid, ev);
    chk("sat_data",  o2_tx_data, ed);
    chk("sat_reply_cnt", o2_reply_cnt, sat(m_reply, 3));
    chk("sat_drop_cnt",  o2_drop_cnt,  sat(m_drop, 3));
  endtask

  task automatic step(input logic [1:0] t, input logic [47:0] sha, input logic [31:0] spa,
                      input logic [31:0] tpa, input logic en, input logic rdy);
    i_pkt_type = t;
    i_SHA      = sha;
    i_SPA      = spa;
    i_TPA      = tpa;
    i_enable   = en;
    i_tx_ready = rdy;
    if (o_tx_valid === 1'b1 && rdy) acc.push_back(o_tx_data);
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++)
      step(2'd0, 48'h0, 32'h0, 32'h0, 1'b1, rdy);
  endtask

  task automatic req(input logic [31:0] tpa, input logic en, input logic rdy);
    step(2'd1, 48'h001122334455, 32'hC0A80064, tpa, en, rdy);
  endtask

  initial begin
    exp1 = '{32'h00112233, 32'h445502AA, 32'hBBCCDDEE, 32'h08060001,
             32'h08000604, 32'h000202AA, 32'hBBCCDDEE, 32'hC0A80001,
             32'h00112233, 32'h4455C0A8, 32'h00640000};
    i_local_ip  = 32'hC0A80001;
    i_local_mac = 48'h02AABBCCDDEE;

    // Reset state
    rst_n = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Basic reply with ready held high, then the hold-off gap
    acc.delete();
    req(32'hC0A80001, 1'b1, 1'b1);
    idle(30, 1'b1);
    chk("frame1_len", acc.size(), 11);
    for (int i = 0; i < 11 && i < acc.size(); i++)
      chk($sformatf("frame1_w%0d", i), acc[i], exp1[i]);

    // Wrong target IP, then responder disabled: both ignored
    req(32'hC0A80002, 1'b1, 1'b1);
    idle(3, 1'b1);
    req(32'hC0A80001, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Ready toggling every cycle
    acc.delete();
    req(32'hC0A80001, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) idle(1, logic'(i % 2));
    idle(20, 1'b1);
    chk("toggle_len", acc.size(), 11);
    for (int i = 0; i < 11 && i < acc.size(); i++)
      chk($sformatf("toggle_w%0d", i), acc[i], exp1[i]);

    // Drops during SEND (at W5) and during GAP; local MAC changes mid-frame
    req(32'hC0A80001, 1'b1, 1'b1);
    idle(5, 1'b1);
    i_local_mac = 48'h0A0B0C0D0E0F;
    step(2'd1, 48'h665544332211, 32'h0A000001, 32'hC0A80001, 1'b1, 1'b1);
    i_local_mac = 48'h02AABBCCDDEE;
    idle(12, 1'b1);
    step(2'd1, 48'h665544332211, 32'h0A000001, 32'hC0A80001, 1'b1, 1'b1);
    idle(20, 1'b1);
    req(32'hC0A80001, 1'b1, 1'b1);
    idle(30, 1'b1);

    // Reset pulse while W6 is on the bus, then a fresh full frame
    req(32'hC0A80001, 1'b1, 1'b1);
    idle(6, 1'b1);
    rst_n = 1'b0;
    idle(1, 1'b1);
    rst_n = 1'b1;
    idle(2, 1'b1);
    acc.delete();
    req(32'hC0A80001, 1'b1, 1'b1);
    idle(30, 1'b1);
    chk("post_reset_len", acc.size(), 11);
    if (acc.size() > 0) chk("post_reset_w0", acc[0], exp1[0]);

    // Five sequential replies: 2-bit counter must stick at 3
    for (int i = 0; i < 5; i++) begin
      req(32'hC0A80001, 1'b1, 1'b1);
      idle(30, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  t;
      logic [31:0] tpa;
      if ($urandom_range(49, 0) == 0) i_local_ip  = $urandom();
      if ($urandom_range(49, 0) == 0) i_local_mac = 48'({$urandom(), $urandom()});
      t   = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'd0;
      if ($urandom_range(5, 0) == 0) t = 2'd1;
      tpa = ($urandom_range(1, 0) == 1) ? i_local_ip : $urandom();
      if ($urandom_range(199, 0) == 0) rst_n = 1'b0;
      step(t, 48'({$urandom(), $urandom()}), $urandom(), tpa,
           $urandom_range(4, 0) != 0, $urandom_range(9, 0) < 7);
      rst_n = 1'b1;
    end
    idle(40, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
